// File: rtl/game_pkg.sv
// Shared types and widths for the guessing game: round controller, round timer
// and display decoder all agree on these encodings.
package game_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_PLAY,
        S_HIT,
        S_MISS,
        S_WIN,
        S_LOSE
    } state_e;

    localparam int                  LEVEL_W   = 3;
    localparam logic [LEVEL_W-1:0]  LEVEL_MIN = 3'd1;
    localparam int                  SCORE_W   = 8;
    localparam logic [SCORE_W-1:0]  SCORE_MAX = 8'd255;
    localparam int                  LIVES_W   = 3;
    localparam int                  HITS_W    = 4;
    localparam int                  HOLD_W    = 4;

    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        return (s == SCORE_MAX) ? s : s + 8'd1;
    endfunction

endpackage

// File: rtl/tick_hold_counter.sv
// Counts tick pulses since the last clear; done once the count reaches limit.
// Saturates at the top so a long hold never wraps back below the limit.
module tick_hold_counter
    import game_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              tick,
    input  logic [HOLD_W-1:0] limit,
    output logic              done
);

    logic [HOLD_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (tick && (cnt_q != {HOLD_W{1'b1}}))
            cnt_d = cnt_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign done = (cnt_q >= limit);

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer: tracks level/lives/score, drives the round timer, and turns
// guesses and timeouts into hit/miss feedback and the final win/lose result.
module game_round_ctrl
    import game_pkg::*;
#(
    parameter int LIVES          = 3,
    parameter int MAX_LEVEL      = 5,
    parameter int HITS_PER_LEVEL = 4,
    parameter int HOLD_TICKS     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               start,
    input  logic               guess_valid,
    input  logic               guess_correct,
    input  logic               timeout,
    output logic [LEVEL_W-1:0] cur_level,
    output logic               timer_en,
    output logic               timer_rst_n,
    output logic [LIVES_W-1:0] lives,
    output logic [SCORE_W-1:0] score,
    output logic               hit_flash,
    output logic               miss_flash,
    output logic               game_over,
    output logic               win
);

    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
    localparam logic [LEVEL_W-1:0] LEVEL_TOP  = LEVEL_W'(MAX_LEVEL);
    localparam logic [HITS_W-1:0]  HITS_TOP   = HITS_W'(HITS_PER_LEVEL);
    localparam logic [HOLD_W-1:0]  HOLD_LIM   = HOLD_W'(HOLD_TICKS);

    state_e             state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [HITS_W-1:0]  hits_q, hits_d;
    logic               win_pend_q, win_pend_d;
    logic               first_q;
    logic               hold_clear, hold_done;
    logic               in_hold;

    assign in_hold    = (state_q == S_HIT) || (state_q == S_MISS);
    // Counter sits at zero outside the hold and during the entry cycle, so a
    // tick coinciding with entry is never counted.
    assign hold_clear = !in_hold || first_q;

    tick_hold_counter u_hold (
        .clk   (clk),
        .rst   (rst),
        .clear (hold_clear),
        .tick  (tick),
        .limit (HOLD_LIM),
        .done  (hold_done)
    );

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        lives_d    = lives_q;
        score_d    = score_q;
        hits_d     = hits_q;
        win_pend_d = win_pend_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_ARM;
            S_ARM:  state_d = S_PLAY;
            S_PLAY: begin
                if (guess_valid && guess_correct) begin
                    state_d = S_HIT;
                    score_d = score_inc(score_q);
                    if (hits_q + 4'd1 >= HITS_TOP) begin
                        hits_d = '0;
                        if (level_q >= LEVEL_TOP) win_pend_d = 1'b1;
                        else                      level_d    = level_q + 3'd1;
                    end else begin
                        hits_d = hits_q + 4'd1;
                    end
                end else if (guess_valid || timeout) begin
                    state_d = S_MISS;
                    if (lives_q != '0) lives_d = lives_q - 3'd1;
                end
            end
            S_HIT, S_MISS: begin
                // Counters were updated on entry; the game-ending outcome
                // skips the hold and is taken straight from the entry cycle.
                if (first_q && win_pend_q)
                    state_d = S_WIN;
                else if (first_q && (state_q == S_MISS) && (lives_q == '0))
                    state_d = S_LOSE;
                else if (hold_done)
                    state_d = S_ARM;
            end
            S_WIN, S_LOSE: if (start) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_IDLE) begin
            level_d    = LEVEL_MIN;
            lives_d    = LIVES_INIT;
            score_d    = '0;
            hits_d     = '0;
            win_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            level_q     <= LEVEL_MIN;
            lives_q     <= LIVES_INIT;
            score_q     <= '0;
            hits_q      <= '0;
            win_pend_q  <= 1'b0;
            first_q     <= 1'b0;
            timer_en    <= 1'b0;
            timer_rst_n <= 1'b0;
            hit_flash   <= 1'b0;
            miss_flash  <= 1'b0;
            game_over   <= 1'b0;
            win         <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            lives_q     <= lives_d;
            score_q     <= score_d;
            hits_q      <= hits_d;
            win_pend_q  <= win_pend_d;
            first_q     <= (state_q == S_PLAY) && ((state_d == S_HIT) || (state_d == S_MISS));
            timer_en    <= (state_d == S_PLAY);
            timer_rst_n <= (state_d == S_PLAY);
            hit_flash   <= (state_d == S_HIT);
            miss_flash  <= (state_d == S_MISS);
            game_over   <= (state_d == S_WIN) || (state_d == S_LOSE);
            win         <= (state_d == S_WIN);
        end
    end

    assign cur_level = level_q;
    assign lives     = lives_q;
    assign score     = score_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl with default parameters
// (LIVES=3, MAX_LEVEL=5, HITS_PER_LEVEL=4, HOLD_TICKS=2).
module tb_game_round_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0, start = 1'b0, guess_valid = 1'b0, guess_correct = 1'b0, timeout = 1'b0;
    logic [2:0] cur_level, lives;
    logic [7:0] score;
    logic       timer_en, timer_rst_n, hit_flash, miss_flash, game_over, win;

    int checks = 0;
    int errors = 0;

    game_round_ctrl dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start),
        .guess_valid(guess_valid), .guess_correct(guess_correct), .timeout(timeout),
        .cur_level(cur_level), .timer_en(timer_en), .timer_rst_n(timer_rst_n),
        .lives(lives), .score(score), .hit_flash(hit_flash), .miss_flash(miss_flash),
        .game_over(game_over), .win(win)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic new_game();
        rst = 1'b0; cyc(); rst = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;
        cyc();
    endtask

    // From PLAY: one correct guess then a full 2-tick hold, back in PLAY.
    task automatic hit_round();
        guess_valid = 1'b1; guess_correct = 1'b1; cyc();
        guess_valid = 1'b0; guess_correct = 1'b0;
        cyc();
        tick = 1'b1; cyc(); cyc(); tick = 1'b0;
        cyc(); cyc();
    endtask

    task automatic test_reset();
        cyc(); cyc();
        checks++;
        if ({cur_level, lives, score} !== {3'd1, 3'd3, 8'd0}) begin
            errors++; $display("FAIL reset_counters: got lvl=%0d lives=%0d score=%0d expected 1 3 0", cur_level, lives, score);
        end
        checks++;
        if ({timer_en, timer_rst_n, hit_flash, miss_flash, game_over, win} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 000000", {timer_en, timer_rst_n, hit_flash, miss_flash, game_over, win});
        end
        rst = 1'b1; cyc();
        checks++;
        if ({timer_en, timer_rst_n} !== 2'b00) begin
            errors++; $display("FAIL idle_timer: got en/rst_n=%b expected 00", {timer_en, timer_rst_n});
        end
    endtask

    task automatic test_start();
        start = 1'b1; cyc(); start = 1'b0;
        checks++;
        if ({timer_en, timer_rst_n} !== 2'b00) begin
            errors++; $display("FAIL arm_timer: got en/rst_n=%b expected 00", {timer_en, timer_rst_n});
        end
        cyc();
        checks++;
        if ({timer_en, timer_rst_n} !== 2'b11) begin
            errors++; $display("FAIL play_timer: got en/rst_n=%b expected 11", {timer_en, timer_rst_n});
        end
        start = 1'b1; cyc(); start = 1'b0;
        checks++;
        if ({timer_en, game_over, cur_level, lives} !== {1'b1, 1'b0, 3'd1, 3'd3}) begin
            errors++; $display("FAIL start_in_play: got en=%b go=%b lvl=%0d lives=%0d expected 1 0 1 3", timer_en, game_over, cur_level, lives);
        end
    endtask

    task automatic test_level_up();
        for (int i = 0; i < 4; i++) begin
            guess_valid = 1'b1; guess_correct = 1'b1; cyc();
            guess_valid = 1'b0; guess_correct = 1'b0;
            checks++;
            if ({hit_flash, timer_en, timer_rst_n, score} !== {3'b100, 8'(i + 1)}) begin
                errors++; $display("FAIL hit_entry%0d: got hf=%b en=%b rn=%b score=%0d expected 1 0 0 %0d", i, hit_flash, timer_en, timer_rst_n, score, i + 1);
            end
            checks++;
            if (cur_level !== ((i == 3) ? 3'd2 : 3'd1)) begin
                errors++; $display("FAIL hit_level%0d: got %0d expected %0d", i, cur_level, (i == 3) ? 2 : 1);
            end
            cyc();
            tick = 1'b1; cyc(); cyc(); tick = 1'b0;
            checks++;
            if (hit_flash !== 1'b1) begin
                errors++; $display("FAIL hit_hold%0d: got hit_flash=%b expected 1", i, hit_flash);
            end
            cyc();
            checks++;
            if ({hit_flash, timer_en, timer_rst_n} !== 3'b000) begin
                errors++; $display("FAIL rearm%0d: got hf/en/rn=%b expected 000", i, {hit_flash, timer_en, timer_rst_n});
            end
            cyc();
            checks++;
            if ({timer_en, timer_rst_n} !== 2'b11) begin
                errors++; $display("FAIL replay%0d: got en/rn=%b expected 11", i, {timer_en, timer_rst_n});
            end
        end
        checks++;
        if ({cur_level, score} !== {3'd2, 8'd4}) begin
            errors++; $display("FAIL level_up: got lvl=%0d score=%0d expected 2 4", cur_level, score);
        end
    endtask

    task automatic test_entry_tick();
        guess_valid = 1'b1; guess_correct = 1'b1; cyc();
        guess_valid = 1'b0; guess_correct = 1'b0;
        tick = 1'b1; cyc(); cyc(); tick = 1'b0; cyc();
        checks++;
        if (hit_flash !== 1'b1) begin
            errors++; $display("FAIL entry_tick: got hit_flash=%b expected 1", hit_flash);
        end
        tick = 1'b1; cyc(); tick = 1'b0; cyc(); cyc();
        checks++;
        if ({hit_flash, timer_en} !== 2'b01) begin
            errors++; $display("FAIL entry_tick_exit: got hf/en=%b expected 01", {hit_flash, timer_en});
        end
    endtask

    task automatic test_lose();
        new_game();
        for (int i = 0; i < 3; i++) begin
            timeout = 1'b1; cyc(); timeout = 1'b0;
            checks++;
            if ({miss_flash, timer_en, lives} !== {2'b10, 3'(2 - i)}) begin
                errors++; $display("FAIL miss%0d: got mf=%b en=%b lives=%0d expected 1 0 %0d", i, miss_flash, timer_en, lives, 2 - i);
            end
            if (i < 2) begin
                cyc(); tick = 1'b1; cyc(); cyc(); tick = 1'b0; cyc(); cyc();
            end
        end
        cyc();
        checks++;
        if ({game_over, win, miss_flash, lives} !== {3'b100, 3'd0}) begin
            errors++; $display("FAIL lose: got go=%b win=%b mf=%b lives=%0d expected 1 0 0 0", game_over, win, miss_flash, lives);
        end
        start = 1'b1; cyc(); start = 1'b0;
        checks++;
        if ({game_over, lives, cur_level, score, timer_rst_n} !== {1'b0, 3'd3, 3'd1, 8'd0, 1'b0}) begin
            errors++; $display("FAIL lose_to_idle: got go=%b lives=%0d lvl=%0d score=%0d rn=%b expected 0 3 1 0 0", game_over, lives, cur_level, score, timer_rst_n);
        end
        start = 1'b1; cyc(); start = 1'b0; cyc();
        checks++;
        if (timer_en !== 1'b1) begin
            errors++; $display("FAIL restart: got timer_en=%b expected 1", timer_en);
        end
    endtask

    task automatic test_win();
        new_game();
        for (int i = 0; i < 16; i++) hit_round();
        checks++;
        if ({cur_level, score} !== {3'd5, 8'd16}) begin
            errors++; $display("FAIL level5: got lvl=%0d score=%0d expected 5 16", cur_level, score);
        end
        for (int i = 0; i < 3; i++) hit_round();
        guess_valid = 1'b1; guess_correct = 1'b1; cyc();
        guess_valid = 1'b0; guess_correct = 1'b0;
        checks++;
        if ({hit_flash, score} !== {1'b1, 8'd20}) begin
            errors++; $display("FAIL final_hit: got hf=%b score=%0d expected 1 20", hit_flash, score);
        end
        cyc();
        checks++;
        if ({win, game_over, hit_flash, cur_level, timer_en} !== {3'b110, 3'd5, 1'b0}) begin
            errors++; $display("FAIL win: got win=%b go=%b hf=%b lvl=%0d en=%b expected 1 1 0 5 0", win, game_over, hit_flash, cur_level, timer_en);
        end
        guess_valid = 1'b1; guess_correct = 1'b1; cyc();
        guess_valid = 1'b0; guess_correct = 1'b0; cyc();
        checks++;
        if ({win, score, hit_flash} !== {1'b1, 8'd20, 1'b0}) begin
            errors++; $display("FAIL win_ignore: got win=%b score=%0d hf=%b expected 1 20 0", win, score, hit_flash);
        end
    endtask

    task automatic test_simultaneous();
        new_game();
        guess_valid = 1'b1; guess_correct = 1'b1; timeout = 1'b1; cyc();
        guess_valid = 1'b0; guess_correct = 1'b0; timeout = 1'b0;
        checks++;
        if ({hit_flash, miss_flash, lives, score} !== {2'b10, 3'd3, 8'd1}) begin
            errors++; $display("FAIL guess_beats_timeout: got hf=%b mf=%b lives=%0d score=%0d expected 1 0 3 1", hit_flash, miss_flash, lives, score);
        end
        cyc(); tick = 1'b1; cyc(); cyc(); tick = 1'b0; cyc(); cyc();
        guess_valid = 1'b1; guess_correct = 1'b0; timeout = 1'b1; cyc();
        guess_valid = 1'b0; timeout = 1'b0;
        checks++;
        if ({hit_flash, miss_flash, lives, score} !== {2'b01, 3'd2, 8'd1}) begin
            errors++; $display("FAIL wrong_guess: got hf=%b mf=%b lives=%0d score=%0d expected 0 1 2 1", hit_flash, miss_flash, lives, score);
        end
    endtask

    task automatic test_reset_in_hold();
        new_game();
        for (int i = 0; i < 8; i++) hit_round();
        guess_valid = 1'b1; guess_correct = 1'b1; cyc();
        guess_valid = 1'b0; guess_correct = 1'b0;
        checks++;
        if ({hit_flash, cur_level, score} !== {1'b1, 3'd3, 8'd9}) begin
            errors++; $display("FAIL pre_reset: got hf=%b lvl=%0d score=%0d expected 1 3 9", hit_flash, cur_level, score);
        end
        rst = 1'b0; cyc(); rst = 1'b1;
        checks++;
        if ({hit_flash, cur_level, score, lives, timer_rst_n, timer_en} !== {1'b0, 3'd1, 8'd0, 3'd3, 2'b00}) begin
            errors++; $display("FAIL reset_in_hold: got hf=%b lvl=%0d score=%0d lives=%0d rn=%b en=%b expected 0 1 0 3 0 0", hit_flash, cur_level, score, lives, timer_rst_n, timer_en);
        end
        cyc(); cyc(); cyc();
        checks++;
        if ({timer_en, hit_flash} !== 2'b00) begin
            errors++; $display("FAIL idle_after_reset: got en/hf=%b expected 00", {timer_en, hit_flash});
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_level_up();
        test_entry_tick();
        test_lose();
        test_win();
        test_simultaneous();
        test_reset_in_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
